// File: rtl/bin2seg_pkg.sv
// Shared types and constants for the binary to two-digit seven-segment converter.
// Segment patterns are active-high abcdefg with a in bit 6.
package bin2seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_ENCODE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [6:0] MAX_VALUE   = 7'd99;
    localparam int         SHIFT_COUNT = 7;

endpackage

// File: rtl/bin2seg_pair_seg7_digit.sv
// One BCD digit to active-high abcdefg segments; dash overrides blank.
// Non-decimal codes show blank.
module seg7_digit
    import bin2seg_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bin2seg_pair.sv
// Sequential double-dabble conversion of 0..99 into a registered two-digit
// seven-segment word; out-of-range values show two dashes.
module bin2seg_pair
    import bin2seg_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW     = 1'b1,
    parameter bit BLANK_LEADING_ZERO = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [6:0]  VALUE,
    output logic        BUSY,
    output logic        DONE,
    output logic        OVF,
    output logic [13:0] Signal
);

    localparam logic [2:0]  LAST_ITER  = 3'(SHIFT_COUNT - 1);
    localparam logic [13:0] BLANK_WORD = SEG_ACTIVE_LOW ? 14'h3FFF : 14'h0000;

    state_t      state;
    state_t      state_next;
    logic [2:0]  cnt;
    logic [6:0]  bin;
    logic [7:0]  scratch;
    logic [3:0]  tens_adj;
    logic [3:0]  units_adj;
    logic [6:0]  tens_seg;
    logic [6:0]  units_seg;
    logic [13:0] seg_word;

    always_comb begin
        tens_adj  = (scratch[7:4] >= 4'd5) ? scratch[7:4] + 4'd3 : scratch[7:4];
        units_adj = (scratch[3:0] >= 4'd5) ? scratch[3:0] + 4'd3 : scratch[3:0];
    end

    seg7_digit u_tens (
        .bcd   (scratch[7:4]),
        .blank (!OVF && BLANK_LEADING_ZERO && (scratch[7:4] == 4'd0)),
        .dash  (OVF),
        .seg   (tens_seg)
    );

    seg7_digit u_units (
        .bcd   (scratch[3:0]),
        .blank (1'b0),
        .dash  (OVF),
        .seg   (units_seg)
    );

    assign seg_word = {tens_seg, units_seg} ^ {14{SEG_ACTIVE_LOW}};
    assign BUSY     = (state != ST_IDLE);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    state_next = (VALUE > MAX_VALUE) ? ST_ENCODE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt == LAST_ITER) begin
                    state_next = ST_ENCODE;
                end
            end
            ST_ENCODE: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            cnt     <= 3'd0;
            bin     <= 7'd0;
            scratch <= 8'd0;
            OVF     <= 1'b0;
            DONE    <= 1'b0;
            Signal  <= BLANK_WORD;
        end else begin
            state <= state_next;
            DONE  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        bin     <= VALUE;
                        scratch <= 8'd0;
                        cnt     <= 3'd0;
                        OVF     <= (VALUE > MAX_VALUE);
                    end
                end
                ST_SHIFT: begin
                    // adjust first, then shift the binary MSB into scratch bit 0
                    {scratch, bin} <= {tens_adj[2:0], units_adj, bin, 1'b0};
                    cnt            <= cnt + 3'd1;
                end
                ST_ENCODE: begin
                    Signal <= seg_word;
                    DONE   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2seg_pair.sv
// Directed bench for bin2seg_pair: stimulus pushes expected words, a DONE monitor
// pops and compares; timing and reset behaviour are checked inline.
module tb_bin2seg_pair;

    logic        CLK   = 1'b0;
    logic        RST   = 1'b1;
    logic        START = 1'b0;
    logic [6:0]  VALUE = 7'd0;
    logic        BUSY;
    logic        DONE;
    logic        OVF;
    logic [13:0] Signal;

    int errors     = 0;
    int checks     = 0;
    int done_count = 0;
    int cyc        = 0;

    typedef struct {
        logic [13:0] sig;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    bin2seg_pair #(
        .SEG_ACTIVE_LOW     (1'b1),
        .BLANK_LEADING_ZERO (1'b1)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .VALUE  (VALUE),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .OVF    (OVF),
        .Signal (Signal)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST && DONE === 1'b1) begin
            done_count++;
            check("sb_nonempty_at_done", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("signal", 32'(Signal), 32'(e.sig));
                check("ovf", 32'(OVF), 32'(e.ovf));
            end
        end
    end

    // Called at a negedge; returns at the negedge where DONE is high.
    task automatic convert(input logic [6:0] v, input logic [13:0] es, input logic eo,
                           input int lat);
        int a0;
        int busy_n;
        bit seen;
        exp_t e;
        e.sig = es;
        e.ovf = eo;
        VALUE = v;
        START = 1'b1;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        START  = 1'b0;
        VALUE  = ~v;
        a0     = cyc;
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (BUSY === 1'b1) busy_n++;
        end
        check("done_seen", 32'(seen), 1);
        check("latency", 32'(cyc - a0), 32'(lat));
        check("busy_cycles", 32'(busy_n), 32'(lat));
        check("busy_at_done", 32'(BUSY), 0);
    endtask

    initial begin
        int dc;
        bit seen;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        check("reset_signal", 32'(Signal), 32'h3FFF);
        check("reset_busy", 32'(BUSY), 0);
        check("reset_done", 32'(DONE), 0);
        check("reset_ovf", 32'(OVF), 0);

        convert(7'd42, 14'b1001100_0010010, 1'b0, 8);
        @(negedge CLK);
        check("done_low_after_pulse", 32'(DONE), 0);

        // back-to-back: each START below lands in the previous DONE cycle
        convert(7'd7,   14'b1111111_0001111, 1'b0, 8);
        convert(7'd99,  14'b0000100_0000100, 1'b0, 8);
        convert(7'd0,   14'b1111111_0000001, 1'b0, 8);
        convert(7'd10,  14'b1001111_0000001, 1'b0, 8);
        convert(7'd100, 14'b1111110_1111110, 1'b1, 1);
        convert(7'd120, 14'b1111110_1111110, 1'b1, 1);
        check("ovf_held", 32'(OVF), 1);
        convert(7'd5,   14'b1111111_0100100, 1'b0, 8);
        check("ovf_cleared", 32'(OVF), 0);

        // START while busy is ignored
        @(negedge CLK);
        dc = done_count;
        begin
            exp_t e;
            e.sig = 14'b1001100_0010010;
            e.ovf = 1'b0;
            sb.push_back(e);
        end
        VALUE = 7'd42;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        VALUE = 7'd0;
        repeat (3) @(negedge CLK);
        VALUE = 7'd13;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("ignore_done_seen", 32'(seen), 1);
        repeat (12) @(negedge CLK);
        check("ignore_single_done", 32'(done_count - dc), 1);

        // reset mid-conversion
        VALUE = 7'd88;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("abort_signal", 32'(Signal), 32'h3FFF);
        check("abort_busy", 32'(BUSY), 0);
        check("abort_done", 32'(DONE), 0);
        check("abort_ovf", 32'(OVF), 0);
        @(negedge CLK);
        RST = 1'b0;
        dc  = done_count;
        repeat (12) @(negedge CLK);
        check("abort_no_done", 32'(done_count - dc), 0);

        convert(7'd30, 14'b0000110_0000001, 1'b0, 8);
        repeat (3) @(negedge CLK);
        check("sb_drained", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
